// File: rtl/pc_fetch_pkg.sv
// Shared types and constants for the PC / fetch-sequencing stage.
// Optional statistics outputs are enabled with the PC_BRANCH_STATS_EN macro.
package pc_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    EXEC = 2'd2
  } fetch_state_e;

  typedef enum logic [1:0] {
    SEQ    = 2'd0,
    BRANCH = 2'd1,
    JUMP   = 2'd2,
    JREG   = 2'd3
  } pc_src_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    return (value == '1) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/pc_fetch_unit_pc_next_sel.sv
// Next-PC arithmetic and priority select (jump_reg > jump > branch > sequential).
// Purely combinational; also flags a JR target with nonzero low bits.
module pc_next_sel
  import pc_fetch_pkg::*;
(
  input  logic [31:0] i_pc,
  input  logic        i_branch_taken,
  input  logic        i_jump,
  input  logic        i_jump_reg,
  input  logic [15:0] i_branch_imm,
  input  logic [25:0] i_jump_index,
  input  logic [31:0] i_reg_target,
  output logic [31:0] o_pc_plus4,
  output logic [31:0] o_next_pc,
  output logic        o_misaligned
);

  logic [31:0] w_branch_target;
  logic [31:0] w_jump_target;
  logic [31:0] w_jreg_target;
  pc_src_e     w_src;

  assign o_pc_plus4      = i_pc + 32'd4;
  assign w_branch_target = o_pc_plus4 + {{14{i_branch_imm[15]}}, i_branch_imm, 2'b00};
  assign w_jump_target   = {o_pc_plus4[31:28], i_jump_index, 2'b00};
  assign w_jreg_target   = {i_reg_target[31:2], 2'b00};
  assign o_misaligned    = i_jump_reg & (|i_reg_target[1:0]);

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    w_src = SEQ;
    if (i_jump_reg)          w_src = JREG;
    else if (i_jump)         w_src = JUMP;
    else if (i_branch_taken) w_src = BRANCH;
  end

  always_comb begin
    o_next_pc = o_pc_plus4;
    case (w_src)
      BRANCH:  o_next_pc = w_branch_target;
      JUMP:    o_next_pc = w_jump_target;
      JREG:    o_next_pc = w_jreg_target;
      default: o_next_pc = o_pc_plus4;
    endcase
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and fetch sequencer: IDLE -> REQ (wait imem_ack) -> EXEC (hold on stall).
// Define PC_BRANCH_STATS_EN to add saturating instr_count / taken_count outputs.
module pc_fetch_unit
  import pc_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        branch_taken,
  input  logic        jump,
  input  logic        jump_reg,
  input  logic [15:0] branch_imm,
  input  logic [25:0] jump_index,
  input  logic [31:0] reg_target,
  input  logic        stall,
  input  logic        imem_ack,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        instr_valid,
  output logic        misaligned
`ifdef PC_BRANCH_STATS_EN
  ,
  output logic [31:0] instr_count,
  output logic [31:0] taken_count
`endif
);

  fetch_state_e r_state;
  fetch_state_e w_next_state;
  logic [31:0]  r_pc;
  logic         r_misaligned;
  logic [31:0]  w_next_pc;
  logic         w_jr_misaligned;
  logic         w_exec_exit;

  pc_next_sel u_pc_next_sel (
    .i_pc           (r_pc),
    .i_branch_taken (branch_taken),
    .i_jump         (jump),
    .i_jump_reg     (jump_reg),
    .i_branch_imm   (branch_imm),
    .i_jump_index   (jump_index),
    .i_reg_target   (reg_target),
    .o_pc_plus4     (pc_plus4),
    .o_next_pc      (w_next_pc),
    .o_misaligned   (w_jr_misaligned)
  );

  // Controls are only honoured on the cycle that actually leaves EXEC.
  assign w_exec_exit = (r_state == EXEC) && !stall;

  always_comb begin
    w_next_state = r_state;
    imem_req     = 1'b0;
    instr_valid  = 1'b0;
    case (r_state)
      IDLE: w_next_state = REQ;
      REQ: begin
        imem_req = 1'b1;
        if (imem_ack) w_next_state = EXEC;
      end
      EXEC: begin
        instr_valid = 1'b1;
        if (!stall) w_next_state = REQ;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_pc         <= RESET_PC;
      r_misaligned <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_exec_exit) begin
        r_pc <= w_next_pc;
        if (w_jr_misaligned) r_misaligned <= 1'b1;
      end
    end
  end

  assign pc         = r_pc;
  assign imem_addr  = r_pc;
  assign misaligned = r_misaligned;

`ifdef PC_BRANCH_STATS_EN
  logic [31:0] r_instr_count;
  logic [31:0] r_taken_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr_count <= '0;
      r_taken_count <= '0;
    end else if (w_exec_exit) begin
      r_instr_count <= sat_inc(r_instr_count);
      if (w_next_pc != pc_plus4) r_taken_count <= sat_inc(r_taken_count);
    end
  end

  assign instr_count = r_instr_count;
  assign taken_count = r_taken_count;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: the driver pushes the PC each fetch should present,
// a monitor pops and compares at every new fetch request.
module tb_pc_fetch_unit;

  localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        branch_taken = 1'b0;
  logic        jump = 1'b0;
  logic        jump_reg = 1'b0;
  logic [15:0] branch_imm = '0;
  logic [25:0] jump_index = '0;
  logic [31:0] reg_target = '0;
  logic        stall = 1'b0;
  logic        imem_ack = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        instr_valid;
  logic        misaligned;
`ifdef PC_BRANCH_STATS_EN
  logic [31:0] instr_count;
  logic [31:0] taken_count;
`endif

  pc_fetch_unit #(.RESET_PC(TB_RESET_PC)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .branch_taken (branch_taken),
    .jump         (jump),
    .jump_reg     (jump_reg),
    .branch_imm   (branch_imm),
    .jump_index   (jump_index),
    .reg_target   (reg_target),
    .stall        (stall),
    .imem_ack     (imem_ack),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .instr_valid  (instr_valid),
    .misaligned   (misaligned)
`ifdef PC_BRANCH_STATS_EN
    ,
    .instr_count  (instr_count),
    .taken_count  (taken_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic        mis;
  } exp_t;

  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  logic        prev_req = 1'b0;
  logic [31:0] m_pc;
  logic        m_mis;
  int          m_instr;
  int          m_taken;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference next-PC from the architectural rules, using plain arithmetic.
  function automatic logic [31:0] model_next(input logic [31:0] cur, input logic bt,
                                             input logic j, input logic jr,
                                             input logic [15:0] imm, input logic [25:0] idx,
                                             input logic [31:0] rt);
    logic [31:0] seq;
    seq = cur + 32'd4;
    if (jr) return rt & ~32'd3;
    if (j)  return (seq & 32'hF000_0000) | ({6'd0, idx} * 32'd4);
    if (bt) return seq + 32'(int'($signed(imm)) * 4);
    return seq;
  endfunction

  // Monitor: each rising imem_req is a new fetch whose address must match the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (imem_req && !prev_req) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_fetch: actual pc=%h required=no fetch", pc);
      end else begin
        e = exp_q.pop_front();
        check("fetch_pc", pc, e.pc);
        check("fetch_addr", imem_addr, e.pc);
        check("pc_plus4", pc_plus4, e.pc + 32'd4);
        check("misaligned", 32'(misaligned), 32'(e.mis));
      end
    end
    prev_req = imem_req;
  end

  task automatic junk_ctrl();
    branch_taken = 1'($urandom);
    jump         = 1'($urandom);
    jump_reg     = 1'($urandom);
    branch_imm   = 16'($urandom);
    jump_index   = 26'($urandom);
    reg_target   = $urandom;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    imem_ack = 1'b0;
    stall    = 1'b0;
    exp_q.delete();
    m_pc    = TB_RESET_PC;
    m_mis   = 1'b0;
    m_instr = 0;
    m_taken = 0;
    @(negedge clk);
    check("rst_pc", pc, TB_RESET_PC);
    check("rst_addr", imem_addr, TB_RESET_PC);
    check("rst_pc_plus4", pc_plus4, TB_RESET_PC + 32'd4);
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_mis", 32'(misaligned), 32'd0);
    exp_q.push_back(exp_t'{pc: TB_RESET_PC, mis: 1'b0});
    rst_n = 1'b1;
    @(negedge clk);
    check("req_after_release", 32'(imem_req), 32'd1);
  endtask

  // Leaves the bench at a negedge with the DUT in REQ, or records a timeout.
  task automatic wait_req();
    for (int i = 0; i < 40; i++) begin
      if (imem_req) return;
      @(negedge clk);
    end
    n_cmp++;
    n_err++;
    $display("FAIL req_timeout: actual imem_req=%b required=1", imem_req);
  endtask

  task automatic run_instr(input logic bt, input logic j, input logic jr,
                           input logic [15:0] imm, input logic [25:0] idx,
                           input logic [31:0] rt, input int n_stall, input int ack_delay);
    logic [31:0] nxt;
    wait_req();
    for (int i = 0; i < ack_delay; i++) begin
      imem_ack = 1'b0;
      stall    = 1'($urandom);
      junk_ctrl();
      @(negedge clk);
      check("req_held", 32'(imem_req), 32'd1);
      check("addr_held", imem_addr, m_pc);
    end
    imem_ack = 1'b1;
    stall    = 1'($urandom);
    junk_ctrl();
    @(negedge clk);
    check("exec_valid", 32'(instr_valid), 32'd1);
    for (int i = 0; i < n_stall; i++) begin
      stall        = 1'b1;
      imem_ack     = 1'($urandom);
      junk_ctrl();
      branch_taken = i[0];
      @(negedge clk);
      check("stall_valid", 32'(instr_valid), 32'd1);
      check("stall_pc", pc, m_pc);
    end
    stall        = 1'b0;
    imem_ack     = 1'($urandom);
    branch_taken = bt;
    jump         = j;
    jump_reg     = jr;
    branch_imm   = imm;
    jump_index   = idx;
    reg_target   = rt;
    nxt   = model_next(m_pc, bt, j, jr, imm, idx, rt);
    m_mis = m_mis | (jr && (rt[1:0] != 2'b00));
    m_instr++;
    if (nxt != m_pc + 32'd4) m_taken++;
    m_pc = nxt;
    exp_q.push_back(exp_t'{pc: m_pc, mis: m_mis});
    @(negedge clk);
    junk_ctrl();
  endtask

  task automatic seq_instr(input int n);
    for (int i = 0; i < n; i++) run_instr(1'b0, 1'b0, 1'b0, '0, '0, '0, 0, 0);
  endtask

  task automatic jr_to(input logic [31:0] target);
    run_instr(1'b0, 1'b0, 1'b1, '0, '0, target, 0, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int t0;
    do_reset();

    // Back-to-back sequential fetches with immediate ack: one instruction per 2 cycles.
    t0 = cyc;
    seq_instr(3);
    wait_req();
    check("throughput_cycles", 32'(cyc - t0), 32'd6);

    jr_to(32'h0000_0100);
    run_instr(1'b1, 1'b0, 1'b0, 16'hFFFE, '0, '0, 0, 0);
    jr_to(32'h0000_0100);
    run_instr(1'b1, 1'b0, 1'b0, 16'h0003, '0, '0, 0, 0);
    jr_to(32'h1000_0040);
    run_instr(1'b1, 1'b1, 1'b0, 16'h1234, 26'h0000010, '0, 0, 0);

    run_instr(1'b1, 1'b0, 1'b0, 16'h0008, '0, '0, 3, 0);
    run_instr(1'b0, 1'b0, 1'b0, '0, '0, '0, 0, 5);

    jr_to(32'hFFFF_FFFC);
    seq_instr(2);

    jr_to(32'h0000_2003);
    seq_instr(10);

    // Asynchronous reset in the middle of a REQ cycle.
    jr_to(32'h0000_0040);
    wait_req();
    imem_ack = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("midreq_req", 32'(imem_req), 32'd0);
    check("midreq_pc", pc, TB_RESET_PC);
    check("midreq_mis", 32'(misaligned), 32'd0);
    do_reset();

    for (int k = 0; k < 300; k++) begin
      logic bt, j, jr;
      bt = 1'($urandom);
      j  = ($urandom_range(0, 7) == 0);
      jr = ($urandom_range(0, 7) == 0);
      run_instr(bt, j, jr, 16'($urandom), 26'($urandom), $urandom,
                int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
    end

    wait_req();
    repeat (2) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
`ifdef PC_BRANCH_STATS_EN
    check("instr_count", instr_count, 32'(m_instr));
    check("taken_count", taken_count, 32'(m_taken));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Program-counter and fetch-sequencing stage of the single-cycle MIPS datapath. Consumes the branch-decision bit from the branch AND gate plus the jump controls, computes the next PC, and sequences instruction-memory fetches through a req/ack handshake. Presents the current PC, PC+4 and an instruction-valid strobe to decode and execute.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- branch_taken  in  1  branch decision (branch & zero)
- jump  in  1  J/JAL control
- jump_reg  in  1  JR control
- branch_imm  in  16  instr[15:0], branch offset in words
- jump_index  in  26  instr[25:0]
- reg_target  in  32  rs value for JR
- stall  in  1  hold current instruction
- imem_ack  in  1  instruction memory has returned data
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address (= pc)
- pc  out  32  current PC
- pc_plus4  out  32  pc + 4, mod 2^32
- instr_valid  out  1  instruction in execute this cycle
- misaligned  out  1  sticky: JR target had nonzero bits [1:0]

## Operation
- FSM states: IDLE, REQ, EXEC.
- IDLE: entered on reset; unconditionally goes to REQ next cycle.
- REQ: imem_req=1, imem_addr=pc; imem_ack high -> EXEC, else stay in REQ.
- EXEC: instr_valid=1. If stall=1: stay in EXEC, pc held, controls ignored. If stall=0: load next PC, go to REQ.
- Next-PC priority: jump_reg > jump > branch_taken > pc_plus4.
- Branch target = pc_plus4 + (sign_extend(branch_imm) << 2), 32-bit wrap.
- Jump target = {pc_plus4[31:28], jump_index, 2'b00}.
- JR target = {reg_target[31:2], 2'b00}; if reg_target[1:0] != 0, misaligned set and held until reset.
- imem_ack outside REQ is ignored.
- Control inputs outside EXEC are ignored.

## Timing
- Reset values: pc=RESET_PC, imem_addr=RESET_PC, pc_plus4=RESET_PC+4, imem_req=0, instr_valid=0, misaligned=0, state=IDLE.
- Reset is asynchronous: asserted mid-REQ drops imem_req in the same cycle and the outstanding fetch is abandoned.
- Minimum throughput is one instruction per 2 cycles: REQ with immediate ack, then EXEC.
- pc updates on the clock edge that leaves EXEC. imem_addr reflects the new pc in the following REQ cycle.
- pc_plus4 is combinational from pc.
- PC 32'hFFFF_FFFC + 4 wraps to 0 with no flag.
- Simultaneous branch_taken and jump: jump wins.
- stall and JR misalignment in the same EXEC cycle: misaligned does not set until the cycle that actually loads the PC.

## Configuration
- PC_BRANCH_STATS_EN defined: adds two outputs.
  - instr_count[31:0]: increments on each EXEC exit.
  - taken_count[31:0]: increments when the loaded PC is not pc_plus4.
  - Both counters saturate at all-ones and reset to 0.
- PC_BRANCH_STATS_EN undefined: the ports and counters are absent. Behaviour is otherwise identical.

## Structure
- Package pc_fetch_pkg holds:
  - FSM state enum (IDLE/REQ/EXEC)
  - default RESET_PC constant
  - next-PC source enum (SEQ/BRANCH/JUMP/JREG)
- One combinational sub-module, pc_next_sel: target arithmetic and the priority select, returning next_pc and the misalignment bit.
- The FSM, registers and counters live in the top.

## Test plan
- Reset then release, imem_ack tied 1: imem_req rises 1 cycle after release; pc steps 0, 4, 8 with instr_valid every 2nd cycle.
- At pc=0x100 in EXEC, branch_taken=1, branch_imm=16'hFFFE: next pc=0x0FC. With branch_imm=16'h0003: next pc=0x110.
- At pc=0x1000_0040, jump=1, jump_index=26'h0000010 with branch_taken=1 also high: next pc=0x1000_0040 (jump wins over branch).
- jump_reg=1, reg_target=0x0000_2003: next pc=0x2000, misaligned=1 and still 1 after 10 further fetches.
- stall=1 for 3 EXEC cycles with branch_taken toggling: pc and instr_valid held. On the stall=0 cycle only the controls present then are applied. Separately, hold imem_ack=0 for 5 cycles: imem_req stays high, imem_addr stable.
- Assert rst_n low mid-REQ at pc=0x40: imem_req drops immediately and pc=RESET_PC. Also run pc=0xFFFF_FFFC sequential, which must wrap to 0. With PC_BRANCH_STATS_EN defined, run 4 instructions including 1 branch and 1 jump: instr_count=4, taken_count=2.
